// File: rtl/rc4_stream.sv
// rc4_stream: runtime-keyed RC4 cipher core with valid/ready key, input and output byte streams.
// Defining RC4_DROP_EN adds a DROP state that discards DROP_BYTES keystream bytes (RC4-dropN).
module rc4_stream #(
  parameter int MAX_KEY_LEN = 16,
  parameter int LEN_W       = 5,
  parameter int DROP_BYTES  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] key_len,
  input  logic             key_valid,
  input  logic [7:0]       key_data,
  output logic             key_ready,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  localparam int               KI_W    = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_KEY_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_INIT, S_KSA, S_GEN, S_OUT
`ifdef RC4_DROP_EN
    , S_DROP
`endif
  } state_t;

  state_t           r_state;
  logic [7:0]       r_s [256];
  logic [7:0]       r_key [MAX_KEY_LEN];
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_n;
  logic [LEN_W-1:0] r_kidx;
  logic [7:0]       r_cnt;
  logic [7:0]       r_i;
  logic [7:0]       r_j;
`ifdef RC4_DROP_EN
  logic [15:0]      r_drop;
`else
  // DROP_BYTES is accepted for interface compatibility but has no effect here.
  logic             w_unused_drop;
  assign w_unused_drop = |DROP_BYTES;
`endif

  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l != '0) && (l <= MAX_LEN);
  endfunction

  // KSA step: new j and the two entries to swap
  logic [7:0] w_si, w_kbyte, w_jk, w_sjk;
  assign w_si    = r_s[r_cnt];
  assign w_kbyte = r_key[r_kidx[KI_W-1:0]];
  assign w_jk    = r_j + w_si + w_kbyte;
  assign w_sjk   = r_s[w_jk];

  // PRGA step; the keystream byte is looked up in the array as it will be after the swap
  logic [7:0] w_in, w_sin, w_jn, w_sjn, w_t, w_kt;
  assign w_in  = r_i + 8'd1;
  assign w_sin = r_s[w_in];
  assign w_jn  = r_j + w_sin;
  assign w_sjn = r_s[w_jn];
  assign w_t   = w_sin + w_sjn;
  assign w_kt  = (w_t == w_in) ? w_sjn :
                 (w_t == w_jn) ? w_sin : r_s[w_t];

  assign key_ready = (r_state == S_KEY);
  assign in_ready  = (r_state == S_GEN);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_n       <= '0;
      r_kidx    <= '0;
      r_cnt     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
`ifdef RC4_DROP_EN
      r_drop    <= '0;
`endif
    end else if (start) begin
      // start restarts from any state; a pending output byte is discarded
      out_valid <= 1'b0;
      if (len_ok(key_len)) begin
        r_state <= S_KEY;
        r_len   <= key_len;
        r_n     <= '0;
        err     <= 1'b0;
      end else begin
        r_state <= S_IDLE;
        err     <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: ;
        S_KEY: begin
          if (key_valid) begin
            r_key[r_n[KI_W-1:0]] <= key_data;
            r_n <= r_n + LEN_W'(1);
            if (r_n == r_len - LEN_W'(1)) begin
              r_state <= S_INIT;
              r_cnt   <= '0;
            end
          end
        end
        S_INIT: begin
          r_s[r_cnt] <= r_cnt;
          r_cnt      <= r_cnt + 8'd1;
          if (r_cnt == 8'hFF) begin
            r_state <= S_KSA;
            r_j     <= '0;
            r_kidx  <= '0;
          end
        end
        S_KSA: begin
          r_s[r_cnt] <= w_sjk;
          r_s[w_jk]  <= w_si;
          r_j        <= w_jk;
          r_kidx     <= (r_kidx == r_len - LEN_W'(1)) ? '0 : r_kidx + LEN_W'(1);
          r_cnt      <= r_cnt + 8'd1;
          if (r_cnt == 8'hFF) begin
            r_i <= '0;
            r_j <= '0;
`ifdef RC4_DROP_EN
            r_drop <= '0;
            if (DROP_BYTES > 0) r_state <= S_DROP;
            else                r_state <= S_GEN;
`else
            r_state <= S_GEN;
`endif
          end
        end
`ifdef RC4_DROP_EN
        S_DROP: begin
          r_i        <= w_in;
          r_j        <= w_jn;
          r_s[w_in]  <= w_sjn;
          r_s[w_jn]  <= w_sin;
          r_drop     <= r_drop + 16'd1;
          if (r_drop == 16'(DROP_BYTES - 1)) r_state <= S_GEN;
        end
`endif
        S_GEN: begin
          if (in_valid) begin
            r_i       <= w_in;
            r_j       <= w_jn;
            r_s[w_in] <= w_sjn;
            r_s[w_jn] <= w_sin;
            out_data  <= in_data ^ w_kt;
            out_valid <= 1'b1;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_GEN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rc4_stream.md
Name: rc4_stream

Overview:
- Parametrised RC4 cipher core, successor to the fixed-key-length rc4 keystream generator.
- Supports a runtime key length up to MAX_KEY_LEN and accepts key bytes through a valid/ready handshake.
- XORs the keystream with an input byte stream, using valid/ready on both data sides.
- Sits between the HPS-side byte FIFO and the output FIFO in the DE0-Nano-SoC fabric.

Parameters:
- MAX_KEY_LEN, 16, maximum key length in bytes (1..256); the key register file is sized to this.
- LEN_W, 5, width of key_len; must satisfy 2^LEN_W > MAX_KEY_LEN.
- DROP_BYTES, 0, number of initial keystream bytes discarded; used only with RC4_DROP_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new key session; samples key_len.
- key_len  in  LEN_W  key length in bytes, sampled on start.
- key_valid  in  1  key byte available.
- key_data  in  8  key byte, first byte is K[0].
- key_ready  out  1  core accepts key byte.
- in_valid  in  1  plaintext/ciphertext byte available.
- in_data  in  8  input byte.
- in_ready  out  1  core accepts input byte.
- out_valid  out  1  result byte available.
- out_data  out  8  in_data XOR keystream byte.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag for an illegal key_len.

Behaviour:
- Reset (rst=0 at a clock edge) puts the core in IDLE. Reset values: key_ready=0, in_ready=0, out_valid=0, out_data=0, busy=0, err=0, i=0, j=0. S contents are don't-care.
- Reset overrides every state, including mid-KSA and mid-stream.
- The state register holds IDLE, KEY, INIT, KSA, DROP, GEN, OUT.
- IDLE:
  - On start with 1<=key_len<=MAX_KEY_LEN: latch len, clear err, go to KEY.
  - On start with key_len=0 or key_len>MAX_KEY_LEN: set err=1 and stay in IDLE.
- KEY:
  - key_ready=1. Each key_valid&&key_ready stores byte at index n, then n++.
  - After byte len-1 is accepted, go to INIT on the next cycle.
  - Key bytes offered outside KEY are not accepted.
- INIT: writes S[c]=c for c=0..255, one entry per cycle (256 cycles), then goes to KSA with j=0.
- KSA:
  - 256 cycles, c=0..255.
  - Each cycle: j = j + S[c] + K[c mod len] (mod 256), then swap S[c] and S[j] using the new j.
  - c mod len uses a wrapping counter that resets to 0 at len; no divider.
  - Afterwards set i=0, j=0 and go to DROP (when RC4_DROP_EN is defined and DROP_BYTES>0) or to GEN.
- GEN:
  - in_ready=1. On in_valid&&in_ready: i=i+1, j=j+S[i] (mod 256), swap S[i] and S[j], latch the input byte, go to OUT.
- OUT:
  - Computes out_data = byte XOR S[(S[i]+S[j]) mod 256] from post-swap values. out_valid=1.
  - Holds out_valid and out_data stable until out_ready.
  - On the handshake, return to GEN; out_valid deasserts the following cycle unless a new byte completes.
  - Throughput is one byte per 2 cycles with no stalls.
  - No keystream advance occurs while stalled.
- Latency:
  - Key start to first in_ready: len + 1 + 256 + 256 cycles (without drop).
  - Input accept to out_valid: 1 cycle.
- start in any non-IDLE state aborts the session and restarts as from IDLE, including the key_len check.
  - A pending out byte is discarded; out_valid drops.
  - An illegal key_len in this case goes to IDLE with err=1.
- i and j wrap modulo 256 naturally; there is no end-of-stream limit.
- A byte on in_data while not in GEN is not accepted (in_ready=0).

Optional Feature:
- Macro: RC4_DROP_EN.
- Defined: after KSA, DROP state runs DROP_BYTES PRGA iterations (i/j update and swap, 1 cycle each), produces no output, then goes to GEN. This implements RC4-dropN.
- Undefined: DROP state and DROP_BYTES logic are absent, KSA goes directly to GEN, and DROP_BYTES is ignored.

Test Plan:
- Key "Key" (len 3: 4B 65 79), input "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> out BB F3 16 E8 D9 40 AF 0A D3. First in_ready exactly 516 cycles after start.
- Key "Wiki" (57 69 6B 69), input "pedia" -> 10 21 BF 04 20. Key "Secret" (6 bytes), input "Attack at dawn" -> 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
- Backpressure: hold out_ready=0 for 10 cycles on byte 2 of the "Key" vector -> out_valid and out_data=16 stay stable, in_ready=0 throughout, and the remaining bytes still match.
- start with key_len=0, then with key_len=MAX_KEY_LEN+1 -> err=1, busy=0, key_ready stays 0. A following legal start clears err.
- Pulse start during KSA, then drive rst=0 for one edge during GEN -> both sessions abort. A subsequent "Key" session still produces BB F3 16 ..., and all outputs are at reset values right after the rst edge.
- With RC4_DROP_EN and DROP_BYTES=3, key "Key", input 00×3 -> out 81 B7 34 (keystream bytes 4..6 of EB 9F 77 81 B7 34).
